// File: rtl/minisys_mdu_if.sv
// Operand/result bundle between the ID/EXE stage and the multiply/divide unit.
// master = pipeline side (issues operations), slave = the MDU.
interface minisys_mdu_if;
  logic        md;
  logic [1:0]  alu_md;
  logic [31:0] a;
  logic [31:0] b;
  logic        mdcs;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_busy;
  logic        mult_over;
  logic        div_busy;
  logic        div_over;
  logic        keep_md;

  modport master (
    output md, alu_md, a, b,
    input  mdcs, hi, lo, mult_busy, mult_over, div_busy, div_over, keep_md
  );

  modport slave (
    input  md, alu_md, a, b,
    output mdcs, hi, lo, mult_busy, mult_over, div_busy, div_over, keep_md
  );
endinterface

// File: rtl/minisys_mdu.sv
// Iterative multiply/divide unit: fixed-latency MULT/MULTU, radix-2 restoring DIV/DIVU,
// with HI/LO result, one-cycle completion strobes and busy status for the stall logic.
module minisys_mdu #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  minisys_mdu_if.slave mdu
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ITER_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state, stateNext;
  logic [CNT_W-1:0]  count, countNext;
  logic [ITER_W-1:0] iter, iterNext;
  logic [PROD_W-1:0] product, productNext;
  logic [DATA_W-1:0] rem, remNext;
  logic [DATA_W-1:0] quot, quotNext;
  logic [DATA_W-1:0] divisor, divisorNext;
  logic [DATA_W-1:0] dividend, dividendNext;
  logic              negQuot, negQuotNext;
  logic              negRem, negRemNext;
  logic              divZero, divZeroNext;

  logic              mdcsQ, mdcsNext;
  logic [DATA_W-1:0] hiQ, hiNext;
  logic [DATA_W-1:0] loQ, loNext;
  logic              multBusy, multBusyNext;
  logic              multOver, multOverNext;
  logic              divBusy, divBusyNext;
  logic              divOver, divOverNext;
  logic              keepMd, keepMdNext;

  // Operand conditioning, evaluated from the live operands on the start edge
  logic              opSigned;
  logic [PROD_W-1:0] mulA, mulB, mulProduct;
  logic [DATA_W-1:0] absA, absB;

  assign opSigned   = ~mdu.alu_md[0];
  assign mulA       = {{DATA_W{opSigned & mdu.a[DATA_W-1]}}, mdu.a};
  assign mulB       = {{DATA_W{opSigned & mdu.b[DATA_W-1]}}, mdu.b};
  assign mulProduct = PROD_W'(mulA * mulB);
  assign absA = (opSigned && mdu.a[DATA_W-1]) ? DATA_W'(~mdu.a + DATA_W'(1)) : mdu.a;
  assign absB = (opSigned && mdu.b[DATA_W-1]) ? DATA_W'(~mdu.b + DATA_W'(1)) : mdu.b;

  // One restoring shift-subtract step; remainder stays below divisor so 32 bits suffice
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] stepRem, stepQuot, finRem, finQuot;

  assign shifted  = {rem, quot[DATA_W-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign stepRem  = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign stepQuot = {quot[DATA_W-2:0], ~diff[DATA_W]};
  assign finQuot  = negQuot ? DATA_W'(~stepQuot + DATA_W'(1)) : stepQuot;
  assign finRem   = negRem  ? DATA_W'(~stepRem + DATA_W'(1))  : stepRem;

  // Next-state and next-output logic
  always_comb begin
    stateNext    = state;
    countNext    = count;
    iterNext     = iter;
    productNext  = product;
    remNext      = rem;
    quotNext     = quot;
    divisorNext  = divisor;
    dividendNext = dividend;
    negQuotNext  = negQuot;
    negRemNext   = negRem;
    divZeroNext  = divZero;
    mdcsNext     = 1'b0;
    hiNext       = hiQ;
    loNext       = loQ;
    multBusyNext = multBusy;
    multOverNext = 1'b0;
    divBusyNext  = divBusy;
    divOverNext  = 1'b0;

    case (state)
      IDLE, DONE: begin
        stateNext    = IDLE;
        multBusyNext = 1'b0;
        divBusyNext  = 1'b0;
        if (mdu.md) begin
          if (!mdu.alu_md[1]) begin
            stateNext    = MUL;
            multBusyNext = 1'b1;
            countNext    = '0;
            productNext  = mulProduct;
          end else begin
            stateNext    = DIV;
            divBusyNext  = 1'b1;
            iterNext     = '0;
            remNext      = '0;
            quotNext     = absA;
            divisorNext  = absB;
            dividendNext = mdu.a;
            negQuotNext  = opSigned & (mdu.a[DATA_W-1] ^ mdu.b[DATA_W-1]);
            negRemNext   = opSigned & mdu.a[DATA_W-1];
            divZeroNext  = (mdu.b == '0);
          end
        end
      end
      MUL: begin
        if (count == CNT_W'(MULT_CYCLES - 1)) begin
          stateNext    = DONE;
          multBusyNext = 1'b0;
          multOverNext = 1'b1;
          mdcsNext     = 1'b1;
          hiNext       = product[PROD_W-1:DATA_W];
          loNext       = product[DATA_W-1:0];
        end else begin
          countNext = count + CNT_W'(1);
        end
      end
      DIV: begin
        remNext  = stepRem;
        quotNext = stepQuot;
        iterNext = iter + ITER_W'(1);
        if (iter == ITER_W'(DATA_W - 1)) begin
          stateNext   = DONE;
          divBusyNext = 1'b0;
          divOverNext = 1'b1;
          mdcsNext    = 1'b1;
          // Divide by zero reports the dividend and an all-ones quotient
          hiNext      = divZero ? dividend : finRem;
          loNext      = divZero ? '1 : finQuot;
        end
      end
      default: begin
        stateNext    = IDLE;
        multBusyNext = 1'b0;
        divBusyNext  = 1'b0;
      end
    endcase

    keepMdNext = multBusyNext | divBusyNext;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      iter     <= '0;
      product  <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      dividend <= '0;
      negQuot  <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
      mdcsQ    <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
      multBusy <= 1'b0;
      multOver <= 1'b0;
      divBusy  <= 1'b0;
      divOver  <= 1'b0;
      keepMd   <= 1'b0;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      iter     <= iterNext;
      product  <= productNext;
      rem      <= remNext;
      quot     <= quotNext;
      divisor  <= divisorNext;
      dividend <= dividendNext;
      negQuot  <= negQuotNext;
      negRem   <= negRemNext;
      divZero  <= divZeroNext;
      mdcsQ    <= mdcsNext;
      hiQ      <= hiNext;
      loQ      <= loNext;
      multBusy <= multBusyNext;
      multOver <= multOverNext;
      divBusy  <= divBusyNext;
      divOver  <= divOverNext;
      keepMd   <= keepMdNext;
    end
  end

  assign mdu.mdcs      = mdcsQ;
  assign mdu.hi        = hiQ;
  assign mdu.lo        = loQ;
  assign mdu.mult_busy = multBusy;
  assign mdu.mult_over = multOver;
  assign mdu.div_busy  = divBusy;
  assign mdu.div_over  = divOver;
  assign mdu.keep_md   = keepMd;

endmodule

// File: tb/tb_minisys_mdu.sv
// Directed self-checking bench for minisys_mdu: multiply/divide results, latencies,
// status pulses, reset abort, ignored starts and back-to-back issue.
module tb_minisys_mdu;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  minisys_mdu_if mdu4();
  minisys_mdu_if mdu1();

  minisys_mdu #(.MULT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .mdu(mdu4));
  minisys_mdu #(.MULT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .mdu(mdu1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge E0, returns in cycle E0+1
  task automatic startOp(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    mdu4.md     = 1'b1;
    mdu4.alu_md = op;
    mdu4.a      = av;
    mdu4.b      = bv;
    @(negedge clk);
    mdu4.md = 1'b0;
  endtask

  // Starting in cycle E0+1: checks lat busy cycles, then the DONE cycle, optionally an idle cycle
  task automatic expectRun(input bit isDiv, input int lat,
                           input logic [31:0] eHi, input logic [31:0] eLo,
                           input logic [31:0] holdHi, input logic [31:0] holdLo,
                           input bit thenIdle);
    for (int k = 1; k <= lat; k++) begin
      checkEq("busy", isDiv ? mdu4.div_busy : mdu4.mult_busy, 32'd1);
      checkEq("other_busy", isDiv ? mdu4.mult_busy : mdu4.div_busy, 32'd0);
      checkEq("keep_md_busy", mdu4.keep_md, 32'd1);
      checkEq("mdcs_busy", mdu4.mdcs, 32'd0);
      checkEq("over_busy", mdu4.mult_over | mdu4.div_over, 32'd0);
      checkEq("hi_hold", mdu4.hi, holdHi);
      checkEq("lo_hold", mdu4.lo, holdLo);
      @(negedge clk);
    end
    checkEq("mdcs_done", mdu4.mdcs, 32'd1);
    checkEq("over_done", isDiv ? mdu4.div_over : mdu4.mult_over, 32'd1);
    checkEq("other_over_done", isDiv ? mdu4.mult_over : mdu4.div_over, 32'd0);
    checkEq("busy_done", mdu4.mult_busy | mdu4.div_busy, 32'd0);
    checkEq("keep_md_done", mdu4.keep_md, 32'd0);
    checkEq("hi_done", mdu4.hi, eHi);
    checkEq("lo_done", mdu4.lo, eLo);
    if (thenIdle) begin
      @(negedge clk);
      checkEq("mdcs_idle", mdu4.mdcs, 32'd0);
      checkEq("over_idle", mdu4.mult_over | mdu4.div_over, 32'd0);
      checkEq("keep_md_idle", mdu4.keep_md, 32'd0);
      checkEq("hi_idle", mdu4.hi, eHi);
      checkEq("lo_idle", mdu4.lo, eLo);
    end
  endtask

  int pulses;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    mdu4.md = 1'b0; mdu4.alu_md = 2'b00; mdu4.a = '0; mdu4.b = '0;
    mdu1.md = 1'b0; mdu1.alu_md = 2'b00; mdu1.a = '0; mdu1.b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkEq("rst_mdcs", mdu4.mdcs, 32'd0);
    checkEq("rst_busy", {mdu4.mult_busy, mdu4.div_busy}, 32'd0);
    checkEq("rst_over", {mdu4.mult_over, mdu4.div_over}, 32'd0);
    checkEq("rst_keep_md", mdu4.keep_md, 32'd0);
    checkEq("rst_hi", mdu4.hi, 32'h0);
    checkEq("rst_lo", mdu4.lo, 32'h0);
    checkEq("rst_mdcs_m1", mdu1.mdcs, 32'd0);

    // MULT -3 * 5 = -15
    startOp(2'b00, 32'hFFFFFFFD, 32'd5);
    expectRun(1'b0, 4, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h0, 32'h0, 1'b1);

    // MULTU all-ones squared
    startOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expectRun(1'b0, 4, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1);

    // DIV -7 / 2 = -3 rem -1
    startOp(2'b10, 32'hFFFFFFF9, 32'd2);
    expectRun(1'b1, 32, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001, 1'b1);

    // DIV 7 / -2 = -3 rem 1
    startOp(2'b10, 32'd7, 32'hFFFFFFFE);
    expectRun(1'b1, 32, 32'd1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);

    // DIVU 0xFFFFFFFF / 10
    startOp(2'b11, 32'hFFFFFFFF, 32'd10);
    expectRun(1'b1, 32, 32'd5, 32'h19999999, 32'd1, 32'hFFFFFFFD, 1'b1);

    // DIVU by zero
    startOp(2'b11, 32'd100, 32'd0);
    expectRun(1'b1, 32, 32'd100, 32'hFFFFFFFF, 32'd5, 32'h19999999, 1'b1);

    // DIV by zero, negative dividend
    startOp(2'b10, 32'hFFFFFFFB, 32'd0);
    expectRun(1'b1, 32, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFF, 1'b1);

    // DIV signed overflow
    startOp(2'b10, 32'h80000000, 32'hFFFFFFFF);
    expectRun(1'b1, 32, 32'h0, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    // Reset in the middle of a divide
    startOp(2'b10, 32'hFFFFFFF9, 32'd2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkEq("abort_mdcs", mdu4.mdcs, 32'd0);
    checkEq("abort_busy", {mdu4.mult_busy, mdu4.div_busy}, 32'd0);
    checkEq("abort_over", {mdu4.mult_over, mdu4.div_over}, 32'd0);
    checkEq("abort_keep_md", mdu4.keep_md, 32'd0);
    checkEq("abort_hi", mdu4.hi, 32'h0);
    checkEq("abort_lo", mdu4.lo, 32'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (mdu4.mdcs || mdu4.div_over || mdu4.div_busy) pulses++;
      @(negedge clk);
    end
    checkEq("abort_no_activity", 32'(pulses), 32'd0);

    // MULTU 3 * 4 after the abort
    startOp(2'b01, 32'd3, 32'd4);
    expectRun(1'b0, 4, 32'h0, 32'd12, 32'h0, 32'h0, 1'b1);

    // DIV 100 / 7 with md held high (MULT 6*7 presented) through busy and DONE
    mdu4.md = 1'b1; mdu4.alu_md = 2'b10; mdu4.a = 32'd100; mdu4.b = 32'd7;
    @(negedge clk);
    mdu4.alu_md = 2'b00; mdu4.a = 32'd6; mdu4.b = 32'd7;
    expectRun(1'b1, 32, 32'd2, 32'd14, 32'h0, 32'd12, 1'b0);
    @(negedge clk);
    mdu4.md = 1'b0;
    expectRun(1'b0, 4, 32'h0, 32'd42, 32'd2, 32'd14, 1'b1);

    // MULTU with a single-cycle multiply: mdcs in E0+2
    mdu1.md = 1'b1; mdu1.alu_md = 2'b01; mdu1.a = 32'hFFFFFFFF; mdu1.b = 32'hFFFFFFFF;
    @(negedge clk);
    mdu1.md = 1'b0;
    checkEq("m1_busy", mdu1.mult_busy, 32'd1);
    checkEq("m1_mdcs_early", mdu1.mdcs, 32'd0);
    @(negedge clk);
    checkEq("m1_mdcs", mdu1.mdcs, 32'd1);
    checkEq("m1_over", mdu1.mult_over, 32'd1);
    checkEq("m1_busy_done", mdu1.mult_busy, 32'd0);
    checkEq("m1_hi", mdu1.hi, 32'hFFFFFFFE);
    checkEq("m1_lo", mdu1.lo, 32'h00000001);
    @(negedge clk);
    checkEq("m1_mdcs_after", mdu1.mdcs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
